// File: rtl/sobel_edge.sv
// -----------------------------------------------------------------------------
// sobel_edge
//
// Purpose:
//   Computes the Sobel gradient magnitude |Gx|+|Gy| of a 3x3 pixel window,
//   saturates it to 10 bits and thresholds it into a binary edge map. Column
//   and row position are tracked so that windows which straddle a line wrap
//   (first two columns) or the missing first two lines are masked to zero.
//   Three pipeline stages; one window accepted per clock when ien=1.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   aclr                     synchronous clear of position counters and the
//                            pipeline valid bits (frame start); beats ien
//   ien                      window valid
//   matrix_p11..matrix_p33   3x3 window, p11 oldest, p33 newest pixel
//   threshold                edge threshold, travels with its window
//   mag                      saturated |Gx|+|Gy| (0 when masked)
//   edge_o                   1 when mag >= threshold and pixel is not masked
//   edge_pix                 1023 when edge_o=1, else 0
//   oen                      output valid, ien delayed by 3 clocks
// -----------------------------------------------------------------------------
module sobel_edge #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aclr,
    input  logic       ien,
    input  logic [9:0] matrix_p11,
    input  logic [9:0] matrix_p12,
    input  logic [9:0] matrix_p13,
    input  logic [9:0] matrix_p21,
    input  logic [9:0] matrix_p22,
    input  logic [9:0] matrix_p23,
    input  logic [9:0] matrix_p31,
    input  logic [9:0] matrix_p32,
    input  logic [9:0] matrix_p33,
    input  logic [9:0] threshold,
    output logic [9:0] mag,
    output logic       edge_o,
    output logic [9:0] edge_pix,
    output logic       oen
);

    localparam int DATA_W = 10;
    localparam int SUM_W  = DATA_W + 2;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // a + 2*b + c, never overflows 12 bits for 10-bit inputs
    function automatic logic [SUM_W-1:0] sum121(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [SUM_W-1:0] absdiff(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic signed [SUM_W:0] d;
        logic signed [SUM_W:0] n;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        n = -d;
        return (d < 0) ? n[SUM_W-1:0] : d[SUM_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sat10(input logic [SUM_W:0] s);
        return (s > (SUM_W+1)'(1023)) ? 10'd1023 : s[DATA_W-1:0];
    endfunction

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                mask_d;

    logic [SUM_W-1:0]    gxp_p1_q, gxn_p1_q, gyp_p1_q, gyn_p1_q;
    logic [DATA_W-1:0]   thr_p1_q;
    logic                msk_p1_q, vld_p1_q;

    logic [SUM_W-1:0]    ax_p2_q, ay_p2_q;
    logic [DATA_W-1:0]   thr_p2_q;
    logic                msk_p2_q, vld_p2_q;

    logic [DATA_W-1:0]   mag_q, pix_q, mag_d, mag_sat;
    logic                edge_q, edge_d, oen_q;

    // Position tracking: sampled on ien, then advanced; aclr has priority
    // and also discards a simultaneous ien.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mask_d = (col_q < CW'(2)) || (row_q < RW'(2));
        if (aclr) begin
            col_d = '0;
            row_d = '0;
        end else if (ien) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        mag_sat = sat10({1'b0, ax_p2_q} + {1'b0, ay_p2_q});
        mag_d   = msk_p2_q ? '0 : mag_sat;
        edge_d  = !msk_p2_q && (mag_sat >= thr_p2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            gxp_p1_q <= '0;
            gxn_p1_q <= '0;
            gyp_p1_q <= '0;
            gyn_p1_q <= '0;
            thr_p1_q <= '0;
            msk_p1_q <= 1'b0;
            vld_p1_q <= 1'b0;
            ax_p2_q  <= '0;
            ay_p2_q  <= '0;
            thr_p2_q <= '0;
            msk_p2_q <= 1'b0;
            vld_p2_q <= 1'b0;
            mag_q    <= '0;
            edge_q   <= 1'b0;
            pix_q    <= '0;
            oen_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            // stage 1: weighted column/row sums
            gxp_p1_q <= sum121(matrix_p13, matrix_p23, matrix_p33);
            gxn_p1_q <= sum121(matrix_p11, matrix_p21, matrix_p31);
            gyp_p1_q <= sum121(matrix_p31, matrix_p32, matrix_p33);
            gyn_p1_q <= sum121(matrix_p11, matrix_p12, matrix_p13);
            thr_p1_q <= threshold;
            msk_p1_q <= mask_d;
            vld_p1_q <= ien && !aclr;
            // stage 2: absolute gradients
            ax_p2_q  <= absdiff(gxp_p1_q, gxn_p1_q);
            ay_p2_q  <= absdiff(gyp_p1_q, gyn_p1_q);
            thr_p2_q <= thr_p1_q;
            msk_p2_q <= msk_p1_q;
            vld_p2_q <= vld_p1_q && !aclr;
            // stage 3: saturate, mask, threshold
            mag_q    <= mag_d;
            edge_q   <= edge_d;
            pix_q    <= edge_d ? 10'd1023 : 10'd0;
            oen_q    <= vld_p2_q && !aclr;
        end
    end

    assign mag      = mag_q;
    assign edge_o   = edge_q;
    assign edge_pix = pix_q;
    assign oen      = oen_q;

endmodule

// File: tb/tb_sobel_edge.sv
// -----------------------------------------------------------------------------
// tb_sobel_edge
//
// Purpose:
//   Self-checking bench for sobel_edge with an 8x4 image. Windows are driven
//   one per clock (or idle), an independent model computes each expected
//   output and pushes it onto a scoreboard queue together with the drive
//   cycle; a monitor on the falling edge pops entries as oen fires and checks
//   data and the 3-clock latency.
// -----------------------------------------------------------------------------
module tb_sobel_edge;

    localparam int W = 8;
    localparam int H = 4;

    typedef logic [8:0][9:0] win_t;   // [0]=p11 [1]=p12 [2]=p13 [3]=p21 ... [8]=p33

    typedef struct {
        int mag;
        int edg;
        int pix;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       aclr;
    logic       ien;
    win_t       win;
    logic [9:0] threshold;
    logic [9:0] mag;
    logic       edge_o;
    logic [9:0] edge_pix;
    logic       oen;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   col_m  = 0;
    int   row_m  = 0;

    sobel_edge #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aclr       (aclr),
        .ien        (ien),
        .matrix_p11 (win[0]),
        .matrix_p12 (win[1]),
        .matrix_p13 (win[2]),
        .matrix_p21 (win[3]),
        .matrix_p22 (win[4]),
        .matrix_p23 (win[5]),
        .matrix_p31 (win[6]),
        .matrix_p32 (win[7]),
        .matrix_p33 (win[8]),
        .threshold  (threshold),
        .mag        (mag),
        .edge_o     (edge_o),
        .edge_pix   (edge_pix),
        .oen        (oen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic win_t make_win(input int l, input int m, input int r);
        win_t w;
        for (int i = 0; i < 3; i++) begin
            w[3*i]   = 10'(l);
            w[3*i+1] = 10'(m);
            w[3*i+2] = 10'(r);
        end
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    function automatic int px(input win_t w, input int i);
        return int'(w[i]);
    endfunction

    function automatic exp_t model(input win_t w, input int thr, input int c, input int r);
        exp_t e;
        int   gx, gy, s;
        bit   masked;
        gx = (px(w,2) + 2*px(w,5) + px(w,8)) - (px(w,0) + 2*px(w,3) + px(w,6));
        gy = (px(w,6) + 2*px(w,7) + px(w,8)) - (px(w,0) + 2*px(w,1) + px(w,2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = gx + gy;
        if (s > 1023) s = 1023;
        masked = (c < 2) || (r < 2);
        e.mag = masked ? 0 : s;
        e.edg = (!masked && s >= thr) ? 1 : 0;
        e.pix = e.edg ? 1023 : 0;
        e.cyc = 0;
        return e;
    endfunction

    // Present one input beat for one clock; inputs change 1 time unit after
    // the rising edge so they are stable when the next edge samples them.
    task automatic drive(input win_t w, input int thr, input bit v, input bit clr);
        exp_t e;
        win       = w;
        threshold = 10'(thr);
        ien       = v;
        aclr      = clr;
        if (clr) begin
            col_m = 0;
            row_m = 0;
            // anything that would come out after this edge is flushed
            while (q.size() > 0 && q[$].cyc + 3 > cyc) void'(q.pop_back());
        end else if (v) begin
            e     = model(w, thr, col_m, row_m);
            e.cyc = cyc;
            q.push_back(e);
            if (col_m == W - 1) begin
                col_m = 0;
                row_m = (row_m == H - 1) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(win, 0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (oen) begin
                if (q.size() == 0) begin
                    check_eq("spurious_oen", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_eq("latency", cyc, e.cyc + 3);
                    check_eq("mag", int'(mag), e.mag);
                    check_eq("edge", int'(edge_o), e.edg);
                    check_eq("edge_pix", int'(edge_pix), e.pix);
                end
            end else if (q.size() > 0 && q[0].cyc + 3 <= cyc) begin
                e = q.pop_front();
                check_eq("missing_oen", 0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t flat, step, grad;
        flat = make_win(100, 100, 100);
        step = make_win(0, 500, 1023);
        grad = make_win(0, 0, 10);

        rst_n = 1'b1; aclr = 1'b0; ien = 1'b0; threshold = '0; win = '0;
        #2 rst_n = 1'b0;
        win = step; ien = 1'b1; threshold = 10'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mag", int'(mag), 0);
        check_eq("rst_edge", int'(edge_o), 0);
        check_eq("rst_pix", int'(edge_pix), 0);
        check_eq("rst_oen", int'(oen), 0);
        ien = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // aclr pulse, then a single beat at cycle 10
        drive(flat, 0, 1'b0, 1'b1);
        while (cyc < 10) idle(1);
        drive(flat, 1, 1'b1, 1'b0);
        idle(5);

        // flat field frame with random blanking gaps
        drive(flat, 0, 1'b0, 1'b1);
        for (int i = 0; i < W*H; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive(flat, 1, 1'b1, 1'b0);
        end
        // two step frames back to back without aclr (border mask pattern)
        for (int i = 0; i < 2*W*H; i++) drive(step, 512, 1'b1, 1'b0);
        idle(4);

        // small gradient at an unmasked position, threshold boundary
        drive(flat, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2*W + 2; i++) drive(flat, 0, 1'b1, 1'b0);
        drive(grad, 40, 1'b1, 1'b0);
        drive(grad, 41, 1'b1, 1'b0);
        drive(flat, 0, 1'b1, 1'b0);
        drive(grad, 0, 1'b1, 1'b0);
        idle(4);

        // random windows and thresholds
        drive(flat, 0, 1'b0, 1'b1);
        for (int i = 0; i < W*H; i++)
            drive(rand_win(), int'($urandom_range(0, 1023)), 1'b1, 1'b0);
        idle(4);

        // aclr together with ien at pixel 13 empties the pipeline
        drive(flat, 0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) drive(step, 100, 1'b1, 1'b0);
        drive(step, 100, 1'b1, 1'b1);
        for (int i = 0; i < 2*W + 4; i++) drive(step, 100, 1'b1, 1'b0);
        idle(4);

        // reset mid-frame discards in-flight data
        drive(flat, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2*W + 4; i++) drive(step, 100, 1'b1, 1'b0);
        ien   = 1'b0;
        rst_n = 1'b0;
        q.delete();
        col_m = 0;
        row_m = 0;
        #1;
        check_eq("midrst_oen", int'(oen), 0);
        check_eq("midrst_mag", int'(mag), 0);
        check_eq("midrst_edge", int'(edge_o), 0);
        check_eq("midrst_pix", int'(edge_pix), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2*W + 3; i++) drive(step, 100, 1'b1, 1'b0);
        idle(6);

        check_eq("drain_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
